// File: rtl/inst_fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: address/word types, FIFO entry and FSM state.
package inst_fetch_queue_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] inst_t;

    localparam int unsigned INST_BYTES = 4;

    typedef struct packed {
        addr_t pc;
        inst_t inst;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        StRun,
        StDrain
    } fetch_state_t;

    function automatic addr_t word_align(input addr_t a);
        return a & ~addr_t'(INST_BYTES - 1);
    endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// In-order FIFO of fetch entries; flush empties it and overrides push/pop in the same cycle.
module inst_fetch_queue_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  fetch_entry_t               i_data,
    output fetch_entry_t               o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    // Empty FIFO presents zeros so decode never sees stale words.
    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_queue.sv
// Sequential fetch address generator with credit-limited memory requests, response buffering
// and redirect handling that discards stale in-flight responses.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        err
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    addr_t         r_fetch_pc;
    addr_t         r_resp_pc;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_drop;
    fetch_state_t  r_state;
    logic          r_err;

    logic [OW-1:0] w_live;
    logic [OW-1:0] w_outstanding_next;
    logic [OW-1:0] w_drop_next;
    logic [CW-1:0] w_count;
    logic          w_req_valid;
    logic          w_issue;
    logic          w_resp_ok;
    logic          w_resp_live;
    logic          w_push;
    logic          w_pop;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;

    assign w_live = r_outstanding - r_drop;

    // Credit rule: every live request already owns a FIFO slot, so responses never stall.
    assign w_req_valid = fetch_en & ~redirect_valid
                       & (32'(r_outstanding) < MAX_OUTSTANDING)
                       & ((32'(w_count) + 32'(w_live)) < DEPTH);

    assign req_valid = w_req_valid & ~rst;
    assign req_addr  = r_fetch_pc;
    assign w_issue   = req_valid & req_ready;

    assign w_resp_ok   = resp_valid & (r_outstanding != '0);
    assign w_resp_live = w_resp_ok & (r_drop == '0);
    assign w_push      = w_resp_live & ~redirect_valid;
    assign w_pop       = inst_valid & inst_ready;

    assign w_push_entry = '{pc: r_resp_pc, inst: resp_data};

    always_comb begin
        w_outstanding_next = r_outstanding;
        if (w_issue)   w_outstanding_next = w_outstanding_next + OW'(1);
        if (w_resp_ok) w_outstanding_next = w_outstanding_next - OW'(1);
    end

    always_comb begin
        w_drop_next = r_drop;
        if (redirect_valid) begin
            // Everything still in flight is stale; a response landing now is dropped too.
            w_drop_next = r_outstanding - (w_resp_ok ? OW'(1) : OW'(0));
        end else if (w_resp_ok && (r_drop != '0)) begin
            w_drop_next = r_drop - OW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_state       <= StRun;
            r_err         <= 1'b0;
        end else begin
            r_outstanding <= w_outstanding_next;
            r_drop        <= w_drop_next;
            if (resp_valid && (r_outstanding == '0)) r_err <= 1'b1;

            if (redirect_valid) begin
                r_fetch_pc <= word_align(redirect_pc);
                r_resp_pc  <= word_align(redirect_pc);
            end else begin
                if (w_issue) r_fetch_pc <= r_fetch_pc + INST_BYTES;
                if (w_push)  r_resp_pc  <= r_resp_pc + INST_BYTES;
            end

            unique case (r_state)
                StRun:   if (redirect_valid && (w_drop_next != '0)) r_state <= StDrain;
                StDrain: if (w_drop_next == '0) r_state <= StRun;
                default: r_state <= StRun;
            endcase
        end
    end

    inst_fetch_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_push_entry),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign inst_valid = (w_count != '0);
    assign inst       = w_head.inst;
    assign inst_pc    = w_head.pc;
    assign err        = r_err;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with an in-order fixed-latency memory returning word=addr.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 1;
    int cyc     = 0;
    int n_issued = 0;
    int n_wait;

    logic [31:0] q_addr [$];
    int          q_due  [$];
    bit          inject = 1'b0;
    logic [31:0] inject_data = '0;

    inst_fetch_queue #(
        .DEPTH           (4),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .err            (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Sample the handshake before the edge, then drive the memory response after it.
    task automatic tick();
        logic        hs;
        logic [31:0] a;
        @(negedge clk);
        hs = req_valid && req_ready;
        a  = req_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (hs) begin
            n_issued++;
            q_addr.push_back(a);
            q_due.push_back(cyc + lat - 1);
        end
        if (inject) begin
            resp_valid = 1'b1;
            resp_data  = inject_data;
            inject     = 1'b0;
        end else if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            resp_valid = 1'b1;
            resp_data  = q_addr.pop_front();
            void'(q_due.pop_front());
        end else begin
            resp_valid = 1'b0;
            resp_data  = '0;
        end
    endtask

    task automatic do_reset();
        #2;
        rst            = 1'b1;
        resp_valid     = 1'b0;
        resp_data      = '0;
        redirect_valid = 1'b0;
        inject         = 1'b0;
        q_addr.delete();
        q_due.delete();
        #1;
    endtask

    task automatic release_reset();
        fetch_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_issued = 0;
    endtask

    initial begin
        rst            = 1'b1;
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        req_ready      = 1'b1;
        resp_valid     = 1'b0;
        resp_data      = '0;
        inst_ready     = 1'b1;

        // Reset values, with fetch_en high to show req_valid is held low during reset
        #1;
        check("rst req_valid", {31'b0, req_valid}, 32'd0);
        check("rst inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst inst", inst, 32'h0);
        check("rst inst_pc", inst_pc, 32'h0);
        check("rst req_addr", req_addr, 32'h0);
        check("rst err", {31'b0, err}, 32'd0);
        release_reset();

        // 1: sequential fetch, 1-cycle memory, one instruction per cycle
        lat = 1;
        fetch_en = 1'b1;
        #1;
        check("t1 first req_valid", {31'b0, req_valid}, 32'd1);
        check("t1 first req_addr", req_addr, 32'h0);
        tick();
        check("t1 second req_addr", req_addr, 32'h4);
        check("t1 inst_valid latency", {31'b0, inst_valid}, 32'd0);
        tick();
        for (int k = 0; k < 8; k++) begin
            check("t1 stream valid", {31'b0, inst_valid}, 32'd1);
            check("t1 stream pc", inst_pc, 32'(4 * k));
            check("t1 stream inst", inst, 32'(4 * k));
            tick();
        end

        // 4: unaligned redirect while a pop and a push are both pending
        check("t4 pre inst_valid", {31'b0, inst_valid}, 32'd1);
        check("t4 pre inst_pc", inst_pc, 32'h20);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        #1;
        check("t4 req_valid in redirect", {31'b0, req_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t4 flushed inst_valid", {31'b0, inst_valid}, 32'd0);
        check("t4 req_addr", req_addr, 32'h40);
        check("t4 req_valid resumes", {31'b0, req_valid}, 32'd1);
        tick();
        check("t4 still empty", {31'b0, inst_valid}, 32'd0);
        tick();
        check("t4 target valid", {31'b0, inst_valid}, 32'd1);
        check("t4 target pc", inst_pc, 32'h40);
        check("t4 target inst", inst, 32'h40);

        // 2: back-pressure fills exactly DEPTH entries
        do_reset();
        release_reset();
        lat        = 1;
        inst_ready = 1'b0;
        fetch_en   = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("t2 req_valid at credit limit", {31'b0, req_valid}, 32'd0);
        tick();
        check("t2 full inst_valid", {31'b0, inst_valid}, 32'd1);
        check("t2 full head pc", inst_pc, 32'h0);
        tick();
        tick();
        check("t2 req_valid held low", {31'b0, req_valid}, 32'd0);
        check("t2 issued count", 32'(n_issued), 32'd4);

        // 5: spurious response with nothing outstanding
        inject      = 1'b1;
        inject_data = 32'hDEAD_BEEF;
        tick();
        check("t5 err before edge", {31'b0, err}, 32'd0);
        tick();
        check("t5 err set", {31'b0, err}, 32'd1);
        check("t5 head pc unchanged", inst_pc, 32'h0);
        check("t5 head inst unchanged", inst, 32'h0);

        // 2 (cont.): release back-pressure, stream continues in order past 0x10
        inst_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("t2 drain valid", {31'b0, inst_valid}, 32'd1);
            check("t2 drain pc", inst_pc, 32'(4 * k));
            check("t2 drain inst", inst, 32'(4 * k));
            tick();
        end
        check("t5 err sticky", {31'b0, err}, 32'd1);

        // 3: latency-3 memory, redirect with two requests in flight
        do_reset();
        release_reset();
        lat        = 3;
        inst_ready = 1'b1;
        fetch_en   = 1'b1;
        tick();
        tick();
        check("t3 outstanding limit", {31'b0, req_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("t3 req_addr", req_addr, 32'h40);
        check("t3 inst_valid after redirect", {31'b0, inst_valid}, 32'd0);
        n_wait = 0;
        while (!inst_valid && n_wait < 20) begin
            tick();
            n_wait++;
        end
        check("t3 cycles to first live inst", 32'(n_wait), 32'd5);
        check("t3 first pc", inst_pc, 32'h40);
        check("t3 first inst", inst, 32'h40);
        tick();
        check("t3 second pc", inst_pc, 32'h44);
        check("t3 second inst", inst, 32'h44);

        // 6: asynchronous reset mid-cycle with work in flight and queued
        inst_ready = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("t6 pre inst_valid", {31'b0, inst_valid}, 32'd1);
        do_reset();
        check("t6 async inst_valid", {31'b0, inst_valid}, 32'd0);
        check("t6 async req_valid", {31'b0, req_valid}, 32'd0);
        check("t6 async req_addr", req_addr, 32'h0);
        check("t6 async inst_pc", inst_pc, 32'h0);
        check("t6 async err", {31'b0, err}, 32'd0);
        release_reset();
        lat      = 1;
        fetch_en = 1'b1;
        #1;
        check("t6 restart req_valid", {31'b0, req_valid}, 32'd1);
        check("t6 restart req_addr", req_addr, 32'h0);
        tick();
        check("t6 next req_addr", req_addr, 32'h4);
        check("t6 err clear", {31'b0, err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
